// File: rtl/hit_centroid_pkg.sv
// Shared types and widths for the hit centroid tracker.
// State encoding plus accumulator and divider sizing.
package hit_centroid_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    localparam int XW        = 10;
    localparam int YW        = 9;
    localparam int CW        = 19;
    localparam int SW        = 28;
    localparam int DIV_STEPS = 28;
    localparam int STW       = $clog2(DIV_STEPS);

endpackage

// File: rtl/hit_centroid_serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The start cycle already produces the first quotient bit.
module serial_divider
    import hit_centroid_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [SW-1:0] dividend,
    input  logic [CW-1:0] divisor,
    output logic          busy,
    output logic [SW-1:0] quotient
);

    logic [CW-1:0]  r_rem;
    logic [SW-1:0]  r_quo;
    logic [CW-1:0]  r_div;
    logic [STW-1:0] r_cnt;

    logic [CW-1:0]  w_rem_in;
    logic [SW-1:0]  w_quo_in;
    logic [CW-1:0]  w_div;
    logic [CW:0]    w_trial;
    logic           w_ge;
    logic [CW:0]    w_rem_nx;
    logic [SW-1:0]  w_quo_nx;

    // One restoring step from either the fresh operands or the running state
    always_comb begin
        w_rem_in = start ? '0 : r_rem;
        w_quo_in = start ? dividend : r_quo;
        w_div    = start ? divisor : r_div;
        w_trial  = {w_rem_in, w_quo_in[SW-1]};
        w_ge     = (w_trial >= {1'b0, w_div});
        w_rem_nx = w_ge ? (w_trial - {1'b0, w_div}) : w_trial;
        w_quo_nx = {w_quo_in[SW-2:0], w_ge};
    end

    // Load on start, then shift in the remaining quotient bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= w_rem_nx[CW-1:0];
            r_quo <= w_quo_nx;
            r_div <= divisor;
            r_cnt <= STW'(DIV_STEPS - 1);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nx[CW-1:0];
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - STW'(1);
        end
    end

    assign busy     = (r_cnt != '0);
    assign quotient = r_quo;

endmodule

// File: rtl/hit_centroid.sv
// Per-frame hit accumulator with serial centroid divide.
// Publishes pointer position once per video frame.
module hit_centroid
    import hit_centroid_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_HITS = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          VIDEO_HS,
    input  logic          VIDEO_VS,
    input  logic          VIDEO_DE,
    input  logic          iHIT,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic [CW-1:0] oCOUNT,
    output logic          oFOUND,
    output logic          oVALID,
    output logic          oOVERRUN,
    output logic          oDROP
);

    localparam logic [XW-1:0] LP_H   = XW'(H_ACTIVE);
    localparam logic [YW-1:0] LP_V   = YW'(V_ACTIVE);
    localparam logic [CW-1:0] LP_MIN = CW'(MIN_HITS);

    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic           r_vs_d;
    logic           r_de_d;
    logic [CW-1:0]  r_cnt;
    logic [SW-1:0]  r_sx;
    logic [SW-1:0]  r_sy;
    logic           r_ovr;
    state_t         r_state;
    logic [STW-1:0] r_step;
    logic [CW-1:0]  r_snap_cnt;
    logic           r_snap_ovr;
    logic [XW-1:0]  r_ox;
    logic [YW-1:0]  r_oy;
    logic [CW-1:0]  r_ocount;
    logic           r_ofound;
    logic           r_ovalid;
    logic           r_oovr;
    logic           r_odrop;

    logic           w_e;
    logic           w_in;
    logic           w_hit;
    logic [CW-1:0]  w_cnt_nx;
    logic [SW-1:0]  w_sx_nx;
    logic [SW-1:0]  w_sy_nx;
    logic           w_ovr_nx;
    logic           w_found;
    logic           w_start;
    logic           w_busy_x;
    logic           w_busy_y;
    logic [SW-1:0]  w_qx;
    logic [SW-1:0]  w_qy;

    // Frame end detect and this cycle's contribution to the running sums
    always_comb begin
        w_e      = r_vs_d & ~VIDEO_VS;
        w_in     = (r_x < LP_H) && (r_y < LP_V);
        w_hit    = VIDEO_DE & iHIT & w_in;
        w_cnt_nx = r_cnt + CW'(w_hit);
        w_sx_nx  = r_sx + (w_hit ? SW'(r_x) : '0);
        w_sy_nx  = r_sy + (w_hit ? SW'(r_y) : '0);
        w_ovr_nx = r_ovr | (VIDEO_DE & ~w_in);
        w_found  = (w_cnt_nx >= LP_MIN);
        w_start  = w_e && (r_state == IDLE) && w_found;
    end

    // Pixel position tracking from DE and VS edges
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x    <= '0;
            r_y    <= '0;
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
        end else begin
            r_vs_d <= VIDEO_VS;
            r_de_d <= VIDEO_DE;
            if (w_e) begin
                r_x <= '0;
                r_y <= '0;
            end else if (r_de_d && !VIDEO_DE) begin
                r_x <= '0;
                if (r_y != LP_V) r_y <= r_y + YW'(1);
            end else if (VIDEO_DE && r_x != LP_H) begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    // Frame accumulators, cleared at every frame end
    always_ff @(posedge CLK) begin
        if (RST || w_e) begin
            r_cnt <= '0;
            r_sx  <= '0;
            r_sy  <= '0;
            r_ovr <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_sx  <= w_sx_nx;
            r_sy  <= w_sy_nx;
            r_ovr <= w_ovr_nx;
        end
    end

    serial_divider u_div_x (
        .clk      (CLK),
        .rst      (RST),
        .start    (w_start),
        .dividend (w_sx_nx),
        .divisor  (w_cnt_nx),
        .busy     (w_busy_x),
        .quotient (w_qx)
    );

    serial_divider u_div_y (
        .clk      (CLK),
        .rst      (RST),
        .start    (w_start),
        .dividend (w_sy_nx),
        .divisor  (w_cnt_nx),
        .busy     (w_busy_y),
        .quotient (w_qy)
    );

    // Result sequencing: snapshot, divide, publish; frame ends while busy are dropped
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_snap_cnt <= '0;
            r_snap_ovr <= 1'b0;
            r_ox       <= '0;
            r_oy       <= '0;
            r_ocount   <= '0;
            r_ofound   <= 1'b0;
            r_ovalid   <= 1'b0;
            r_oovr     <= 1'b0;
            r_odrop    <= 1'b0;
        end else begin
            r_ovalid <= 1'b0;
            r_odrop  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_e && w_found) begin
                        r_state    <= DIV;
                        r_step     <= STW'(DIV_STEPS - 1);
                        r_snap_cnt <= w_cnt_nx;
                        r_snap_ovr <= w_ovr_nx;
                    end else if (w_e) begin
                        r_state  <= DONE;
                        r_ovalid <= 1'b1;
                        r_ocount <= w_cnt_nx;
                        r_ofound <= 1'b0;
                        r_oovr   <= w_ovr_nx;
                    end
                end
                DIV: begin
                    r_odrop <= w_e;
                    if (r_step == '0) begin
                        r_state  <= DONE;
                        r_ovalid <= 1'b1;
                        r_ox     <= w_qx[XW-1:0];
                        r_oy     <= w_qy[YW-1:0];
                        r_ocount <= r_snap_cnt;
                        r_ofound <= 1'b1;
                        r_oovr   <= r_snap_ovr;
                    end else begin
                        r_step <= r_step - STW'(1);
                    end
                end
                DONE: begin
                    r_odrop <= w_e;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Centroid always lies inside the active area
    a_quo_range: assert property (@(posedge CLK) disable iff (RST)
        (r_state == DIV && r_step == '0) |->
        (!w_busy_x && !w_busy_y &&
         w_qx[SW-1:XW] == '0 && w_qy[SW-1:YW] == '0));

    // Active pixels never overlap horizontal sync
    a_hs_align: assert property (@(posedge CLK) disable iff (RST)
        VIDEO_DE |-> VIDEO_HS);

    assign oX       = r_ox;
    assign oY       = r_oy;
    assign oCOUNT   = r_ocount;
    assign oFOUND   = r_ofound;
    assign oVALID   = r_ovalid;
    assign oOVERRUN = r_oovr;
    assign oDROP    = r_odrop;

endmodule

// File: tb/tb_hit_centroid.sv
// Scoreboard bench for hit_centroid.
// Reference model predicts each result and drop pulse as frames are driven.
module tb_hit_centroid;

    logic        CLK = 1'b0;
    logic        RST;
    logic        VIDEO_HS;
    logic        VIDEO_VS;
    logic        VIDEO_DE;
    logic        iHIT;
    logic [9:0]  oX;
    logic [8:0]  oY;
    logic [18:0] oCOUNT;
    logic        oFOUND;
    logic        oVALID;
    logic        oOVERRUN;
    logic        oDROP;

    hit_centroid dut (
        .CLK      (CLK),
        .RST      (RST),
        .VIDEO_HS (VIDEO_HS),
        .VIDEO_VS (VIDEO_VS),
        .VIDEO_DE (VIDEO_DE),
        .iHIT     (iHIT),
        .oX       (oX),
        .oY       (oY),
        .oCOUNT   (oCOUNT),
        .oFOUND   (oFOUND),
        .oVALID   (oVALID),
        .oOVERRUN (oOVERRUN),
        .oDROP    (oDROP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int c;
        int x;
        int y;
        int n;
        int f;
        int o;
    } exp_t;

    exp_t   sb[$];
    int     dq[$];
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     busy_until = -1;
    int     px = 0;
    int     py = 0;
    int     m_x = 0;
    int     m_y = 0;
    bit     m_vs_d = 1'b0;
    bit     m_de_d = 1'b0;
    int     acc_n = 0;
    longint acc_sx = 0;
    longint acc_sy = 0;
    bit     acc_o = 1'b0;
    exp_t   got_e;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one cycle and advance the reference model
    task automatic step(input bit vs, input bit de, input bit hit);
        exp_t ex;
        bit   e;
        bit   inr;
        VIDEO_HS = 1'b1;
        VIDEO_VS = vs;
        VIDEO_DE = de;
        iHIT     = hit;
        e = m_vs_d && !vs;
        if (de) begin
            inr = (m_x < 640) && (m_y < 480);
            if (hit && inr) begin
                acc_n++;
                acc_sx += m_x;
                acc_sy += m_y;
            end
            if (!inr) acc_o = 1'b1;
        end
        if (e) begin
            if (cyc <= busy_until) begin
                dq.push_back(cyc + 1);
            end else begin
                ex.n = acc_n;
                ex.o = int'(acc_o);
                if (acc_n >= 16) begin
                    ex.f = 1;
                    ex.x = int'(acc_sx / acc_n);
                    ex.y = int'(acc_sy / acc_n);
                    ex.c = cyc + 29;
                    px = ex.x;
                    py = ex.y;
                end else begin
                    ex.f = 0;
                    ex.x = px;
                    ex.y = py;
                    ex.c = cyc + 1;
                end
                busy_until = ex.c;
                sb.push_back(ex);
            end
            acc_n = 0;
            acc_sx = 0;
            acc_sy = 0;
            acc_o = 1'b0;
            m_x = 0;
            m_y = 0;
        end else if (m_de_d && !de) begin
            m_x = 0;
            if (m_y != 480) m_y++;
        end else if (de && m_x != 640) begin
            m_x++;
        end
        m_vs_d = vs;
        m_de_d = de;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        VIDEO_HS = 1'b1;
        VIDEO_VS = 1'b0;
        VIDEO_DE = 1'b0;
        iHIT = 1'b0;
        sb.delete();
        dq.delete();
        busy_until = -1;
        px = 0;
        py = 0;
        m_x = 0;
        m_y = 0;
        m_vs_d = 1'b0;
        m_de_d = 1'b0;
        acc_n = 0;
        acc_sx = 0;
        acc_sy = 0;
        acc_o = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic line(input int len, input int hs, input int he);
        for (int i = 0; i < len; i++) step(1'b1, 1'b1, (i >= hs) && (i < he));
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    // 4-wide block at x 100..103, y 50..53; last row has nlast hits
    task automatic blk(input int nlast);
        step(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 50; l++) line(1, 0, 0);
        for (int l = 0; l < 3; l++) line(104, 100, 104);
        line(104, 100, 100 + nlast);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || dq.size() != 0) && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        chk("drain_pending", sb.size() + dq.size(), 0);
    endtask

    // Output side: match every pulse against the scoreboard
    always @(negedge CLK) begin
        if (!RST) begin
            if (oVALID) begin
                if (sb.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    got_e = sb.pop_front();
                    chk("valid_cycle", cyc, got_e.c);
                    chk("x", oX, got_e.x);
                    chk("y", oY, got_e.y);
                    chk("count", oCOUNT, got_e.n);
                    chk("found", oFOUND, got_e.f);
                    chk("overrun", oOVERRUN, got_e.o);
                end
            end else if (sb.size() != 0 && sb[0].c < cyc) begin
                chk("valid_missing", cyc, sb[0].c);
                void'(sb.pop_front());
            end
            if (oDROP) begin
                if (dq.size() != 0 && dq[0] == cyc) begin
                    chk("drop_cycle", cyc, dq.pop_front());
                end else begin
                    chk("drop_unexpected", 1, 0);
                end
            end else if (dq.size() != 0 && dq[0] < cyc) begin
                chk("drop_missing", cyc, dq[0]);
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        RST = 1'b1;
        VIDEO_HS = 1'b1;
        VIDEO_VS = 1'b1;
        VIDEO_DE = 1'b0;
        iHIT = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();
        chk("rst_x", oX, 0);
        chk("rst_y", oY, 0);
        chk("rst_count", oCOUNT, 0);
        chk("rst_found", oFOUND, 0);
        chk("rst_valid", oVALID, 0);
        chk("rst_overrun", oOVERRUN, 0);
        chk("rst_drop", oDROP, 0);

        blk(4);
        vblank(4);
        drain();
        chk("blk16_x", oX, 101);
        chk("blk16_y", oY, 51);
        chk("blk16_count", oCOUNT, 16);
        chk("blk16_found", oFOUND, 1);

        blk(3);
        vblank(4);
        drain();
        chk("blk15_found", oFOUND, 0);
        chk("blk15_count", oCOUNT, 15);
        chk("blk15_x_hold", oX, 101);

        step(1'b1, 1'b0, 1'b0);
        line(700, 0, 700);
        vblank(4);
        drain();
        chk("ovr_flag", oOVERRUN, 1);
        chk("ovr_x", oX, 319);
        chk("ovr_count", oCOUNT, 640);

        blk(4);
        vblank(4);
        drain();
        chk("ovr_clear", oOVERRUN, 0);

        step(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 40; l++) line(64, 0, 64);
        vblank(4);
        drain();
        chk("dense_x", oX, 31);
        chk("dense_y", oY, 19);
        chk("dense_count", oCOUNT, 2560);

        step(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 20; l++) begin
            int len;
            int a;
            len = $urandom_range(1, 200);
            a = $urandom_range(0, len);
            line(len, a, a + $urandom_range(0, 60));
        end
        vblank(4);
        drain();

        blk(4);
        vblank(10);
        do_reset();
        chk("abort_x", oX, 0);
        chk("abort_y", oY, 0);
        chk("abort_count", oCOUNT, 0);
        chk("abort_valid", oVALID, 0);
        blk(4);
        vblank(4);
        drain();
        chk("post_rst_x", oX, 101);
        chk("post_rst_y", oY, 51);

        blk(4);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
        vblank(4);
        drain();
        chk("drop_result_x", oX, 101);

        blk(3);
        vblank(4);
        drain();
        chk("after_drop_count", oCOUNT, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
